axi_w_buffer: RTL and testbench

// - Parametrised AXI write-data (W) channel buffer between a crossbar slave port and master port.
// - Full valid/ready handshake on both sides; true DEPTH-entry storage; occupancy/almost-full status.
// - Optional store-and-forward gating: beats are released only once a complete burst (WLAST) is held.

---
 rtl/axi_w_buffer.sv | 147 ++++++++++++++
 tb/tb_axi_w_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_w_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : axi_w_buffer
//  Purpose  : AXI write-data (W) channel buffer between a crossbar slave port
//             and master port. DEPTH-entry circular storage with full
//             valid/ready handshaking on both sides and occupancy status.
//             Optional store-and-forward gating releases beats only once a
//             complete burst (WLAST) is held.
//  Config   : `define W_BUFFER_STORE_FWD_EN  -> store-and-forward gating
//             (undefined by default -> cut-through per beat)
//  Ports    : ACLK, ARESETn          clock (rising edge), async active-low reset
//             s_WDATA/WSTRB/WLAST    upstream beat payload
//             s_WVALID / s_WREADY    upstream handshake
//             m_WDATA/WSTRB/WLAST    head-entry payload (0 while m_WVALID=0)
//             m_WVALID / m_WREADY    downstream handshake
//             count, full, empty,    occupancy status, registered-state only
//             almost_full
//  Revision : 1.0  initial release
// ============================================================================
module axi_w_buffer #(
    parameter int DEPTH        = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic [DATA_WIDTH-1:0]    s_WDATA,
    input  logic [STRB_WIDTH-1:0]    s_WSTRB,
    input  logic                     s_WLAST,
    input  logic                     s_WVALID,
    output logic                     s_WREADY,
    output logic [DATA_WIDTH-1:0]    m_WDATA,
    output logic [STRB_WIDTH-1:0]    m_WSTRB,
    output logic                     m_WLAST,
    output logic                     m_WVALID,
    input  logic                     m_WREADY,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] C_AFULL = PW'(AFULL_THRESH);

    // Storage entry: {last, strobes, data}
    typedef struct packed {
        logic                  last;
        logic [STRB_WIDTH-1:0] strb;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             ready_q;          // low in reset, high from first clock after
    logic             w_push, w_pop;
    entry_t           w_head;

    // ------------------------------------------------------------------
    // Status, all from registered state
    // ------------------------------------------------------------------
    assign count       = wr_ptr_q - rd_ptr_q;
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                         (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign almost_full = (count >= C_AFULL);

    // No combinational path from m_WREADY: a pop at full frees the slot,
    // but ready only rises the following cycle.
    assign s_WREADY = ready_q & ~full;

    assign w_push = s_WVALID & s_WREADY;
    assign w_pop  = m_WVALID & m_WREADY;

`ifdef W_BUFFER_STORE_FWD_EN
    // Number of complete bursts (WLAST beats) currently stored.
    logic [PW-1:0] bursts_q, bursts_d;

    always_comb begin
        bursts_d = bursts_q;
        if (w_push && s_WLAST && !(w_pop && w_head.last)) begin
            bursts_d = bursts_q + 1'b1;
        end else if (!(w_push && s_WLAST) && w_pop && w_head.last) begin
            bursts_d = bursts_q - 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            bursts_q <= '0;
        end else begin
            bursts_q <= bursts_d;
        end
    end

    // The full term lets a burst longer than DEPTH drain instead of
    // waiting forever for a WLAST that cannot be stored.
    assign m_WVALID = ~empty & ((bursts_q != '0) | full);
`else
    assign m_WVALID = ~empty;
`endif

    // ------------------------------------------------------------------
    // Pointers
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Storage (not reset; contents are only visible while m_WVALID=1)
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (w_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{last: s_WLAST, strb: s_WSTRB, data: s_WDATA};
        end
    end

    assign w_head  = mem_q[rd_ptr_q[AW-1:0]];
    assign m_WDATA = m_WVALID ? w_head.data : '0;
    assign m_WSTRB = m_WVALID ? w_head.strb : '0;
    assign m_WLAST = m_WVALID ? w_head.last : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_axi_w_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_w_buffer
//  Purpose  : Directed self-checking bench for axi_w_buffer (DEPTH=8).
//             Store-and-forward scenarios build when W_BUFFER_STORE_FWD_EN
//             is defined; otherwise the cut-through scenarios build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_w_buffer;

    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic [DW-1:0] s_WDATA;
    logic [SW-1:0] s_WSTRB;
    logic          s_WLAST;
    logic          s_WVALID;
    logic          s_WREADY;
    logic [DW-1:0] m_WDATA;
    logic [SW-1:0] m_WSTRB;
    logic          m_WLAST;
    logic          m_WVALID;
    logic          m_WREADY;
    logic [3:0]    count;
    logic          full;
    logic          empty;
    logic          almost_full;

    int n_cmp = 0;
    int n_err = 0;

    axi_w_buffer #(
        .DEPTH        (DEPTH),
        .DATA_WIDTH   (DW),
        .STRB_WIDTH   (SW),
        .AFULL_THRESH (DEPTH - 2)
    ) u_dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .s_WDATA     (s_WDATA),
        .s_WSTRB     (s_WSTRB),
        .s_WLAST     (s_WLAST),
        .s_WVALID    (s_WVALID),
        .s_WREADY    (s_WREADY),
        .m_WDATA     (m_WDATA),
        .m_WSTRB     (m_WSTRB),
        .m_WLAST     (m_WLAST),
        .m_WVALID    (m_WVALID),
        .m_WREADY    (m_WREADY),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drive_beat(input logic v, input logic [DW-1:0] d, input logic l);
        s_WVALID = v;
        s_WDATA  = d;
        s_WSTRB  = v ? 4'hF : 4'h0;
        s_WLAST  = l;
    endtask

    initial begin
        ARESETn  = 1'b0;
        m_WREADY = 1'b0;
        drive_beat(1'b0, '0, 1'b0);

        // ---------------- reset state ----------------
        tick();
        tick();
        check_val("rst_wready", s_WREADY, 0);
        check_val("rst_mvalid", m_WVALID, 0);
        check_val("rst_empty",  empty, 1);
        check_val("rst_full",   full, 0);
        check_val("rst_afull",  almost_full, 0);
        check_val("rst_count",  count, 0);
        check_val("rst_mdata",  m_WDATA, 0);
        ARESETn = 1'b1;
        tick();
        check_val("post_rst_wready", s_WREADY, 1);

`ifndef W_BUFFER_STORE_FWD_EN
        // ---------------- fill to full, downstream stalled ----------------
        for (int i = 0; i < DEPTH; i++) begin
            drive_beat(1'b1, 32'h100 + i, i == DEPTH - 1);
            tick();
            check_val("fill_count", count, i + 1);
            check_val("fill_afull", almost_full, (i + 1) >= 6);
            check_val("fill_head",  m_WDATA, 32'h100);
        end
        check_val("full_flag",   full, 1);
        check_val("full_wready", s_WREADY, 0);
        check_val("full_mvalid", m_WVALID, 1);
        check_val("full_strb",   m_WSTRB, 4'hF);

        // 9th beat stalls
        drive_beat(1'b1, 32'h1FF, 1'b0);
        tick();
        check_val("stall_count", count, 8);

        // ---------------- pop at full with upstream still valid ----------------
        m_WREADY = 1'b1;
        check_val("popfull_head", m_WDATA, 32'h100);
        tick();
        m_WREADY = 1'b0;
        drive_beat(1'b0, '0, 1'b0);
        check_val("popfull_count",  count, 7);
        check_val("popfull_wready", s_WREADY, 1);
        check_val("popfull_full",   full, 0);
        check_val("popfull_next",   m_WDATA, 32'h101);

        // ---------------- drain remaining 7 in order ----------------
        m_WREADY = 1'b1;
        for (int j = 1; j < DEPTH; j++) begin
            check_val("drain_data", m_WDATA, 32'h100 + j);
            check_val("drain_last", m_WLAST, j == DEPTH - 1);
            tick();
        end
        check_val("drain_empty",  empty, 1);
        check_val("drain_mvalid", m_WVALID, 0);
        check_val("drain_mdata",  m_WDATA, 0);

        // ---------------- continuous streaming, 20 beats ----------------
        for (int k = 0; k < 20; k++) begin
            drive_beat(1'b1, 32'h200 + k, 1'b0);
            tick();
            check_val("stream_count",  count, 1);
            check_val("stream_mvalid", m_WVALID, 1);
            check_val("stream_data",   m_WDATA, 32'h200 + k);
        end
        drive_beat(1'b0, '0, 1'b0);
        tick();
        m_WREADY = 1'b0;
        check_val("stream_end_empty", empty, 1);
        check_val("stream_end_count", count, 0);
`else
        // ---------------- store-and-forward: 3-beat burst ----------------
        for (int i = 0; i < 3; i++) begin
            drive_beat(1'b1, 32'h400 + i, i == 2);
            tick();
            check_val("sf3_mvalid", m_WVALID, i == 2);
        end
        drive_beat(1'b0, '0, 1'b0);
        check_val("sf3_head", m_WDATA, 32'h400);
        m_WREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_val("sf3_data", m_WDATA, 32'h400 + i);
            check_val("sf3_last", m_WLAST, i == 2);
            tick();
        end
        m_WREADY = 1'b0;
        check_val("sf3_empty",  empty, 1);
        check_val("sf3_mvalid_end", m_WVALID, 0);

        // ---------------- store-and-forward: 10-beat burst ----------------
        begin
            int pushed;
            int popped;
            pushed = 0;
            popped = 0;
            for (int i = 0; i < DEPTH; i++) begin
                drive_beat(1'b1, 32'h300 + i, 1'b0);
                tick();
                pushed++;
                check_val("sf10_gate", m_WVALID, i == DEPTH - 1);
            end
            check_val("sf10_full", full, 1);
            m_WREADY = 1'b1;
            for (int cyc = 0; cyc < 200 && popped < 10; cyc++) begin
                logic do_push;
                logic do_pop;
                drive_beat(pushed < 10, 32'h300 + pushed, pushed == 9);
                do_push = s_WVALID & s_WREADY;
                do_pop  = m_WVALID & m_WREADY;
                if (do_pop) begin
                    check_val("sf10_data", m_WDATA, 32'h300 + popped);
                    check_val("sf10_last", m_WLAST, popped == 9);
                    popped++;
                end
                if (do_push) begin
                    pushed++;
                end
                tick();
            end
            drive_beat(1'b0, '0, 1'b0);
            m_WREADY = 1'b0;
            check_val("sf10_drained", popped, 10);
            check_val("sf10_empty", empty, 1);
            // A leftover burst count would open the gate on the next lone beat.
            drive_beat(1'b1, 32'h3AA, 1'b0);
            tick();
            drive_beat(1'b0, '0, 1'b0);
            check_val("sf10_bursts_zero", m_WVALID, 0);
            tick();
        end
`endif

        // ---------------- reset mid-traffic with 5 entries held ----------------
        m_WREADY = 1'b0;
        ARESETn  = 1'b0;
        tick();
        ARESETn  = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            drive_beat(1'b1, 32'h500 + i, i == 4);
            tick();
        end
        drive_beat(1'b0, '0, 1'b0);
        check_val("mid_pre_count", count, 5);
        ARESETn = 1'b0;
        tick();
        check_val("mid_count",  count, 0);
        check_val("mid_empty",  empty, 1);
        check_val("mid_mvalid", m_WVALID, 0);
        check_val("mid_mdata",  m_WDATA, 0);
        check_val("mid_wready", s_WREADY, 0);
        ARESETn = 1'b1;
        tick();
        check_val("mid_post_wready", s_WREADY, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
